// File: rtl/flash_boot_loader.sv
// Boot-time copier: reads a little-endian image out of 16-bit NOR flash
// and writes it word by word into RAM through a write/ack handshake.
module flash_boot_loader #(
    parameter int unsigned WORD_COUNT  = 256,
    parameter logic [21:0] FLASH_BASE  = 22'h0,
    parameter logic [31:0] RAM_BASE    = 32'h0,
    parameter int unsigned WAIT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [21:0] flash_addr,
    output logic [15:0] flash_data_o,
    output logic        flash_data_oe,
    input  logic [15:0] flash_data_i,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    input  logic        ram_ack
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CMD_SETUP = 3'd1;
    localparam logic [2:0] S_CMD_PULSE = 3'd2;
    localparam logic [2:0] S_CMD_HOLD  = 3'd3;
    localparam logic [2:0] S_RD_LO     = 3'd4;
    localparam logic [2:0] S_RD_HI     = 3'd5;
    localparam logic [2:0] S_RAM_WR    = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    localparam int unsigned KW = (WORD_COUNT < 2) ? 1 : $clog2(WORD_COUNT + 1);
    localparam int unsigned CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(WORD_COUNT - 1);
    localparam logic          NO_WORDS = (WORD_COUNT == 0);

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [KW-1:0] r_k;
    logic          r_busy;
    logic          r_done;
    logic [21:0]   r_flash_addr;
    logic [15:0]   r_flash_data_o;
    logic          r_flash_data_oe;
    logic          r_ce_n;
    logic          r_oe_n;
    logic          r_we_n;
    logic [31:0]   r_ram_addr;
    logic [31:0]   r_ram_wdata;
    logic          r_ram_we;

    logic          w_last;
    logic [31:0]   w_ram_addr_k;

    assign w_last       = (r_cnt == CNT_LAST);
    assign w_ram_addr_k = RAM_BASE + (32'(r_k) << 2);

    // Outputs are loaded together with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_k             <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_flash_addr    <= '0;
            r_flash_data_o  <= '0;
            r_flash_data_oe <= 1'b0;
            r_ce_n          <= 1'b1;
            r_oe_n          <= 1'b1;
            r_we_n          <= 1'b1;
            r_ram_addr      <= '0;
            r_ram_wdata     <= '0;
            r_ram_we        <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state         <= S_CMD_SETUP;
                        r_cnt           <= '0;
                        r_k             <= '0;
                        r_busy          <= 1'b1;
                        r_done          <= 1'b0;
                        r_ce_n          <= 1'b0;
                        r_flash_data_oe <= 1'b1;
                        r_flash_data_o  <= 16'h00FF;
                        r_flash_addr    <= FLASH_BASE;
                    end
                end
                S_CMD_SETUP: begin
                    r_state <= S_CMD_PULSE;
                    r_cnt   <= '0;
                    r_we_n  <= 1'b0;
                end
                S_CMD_PULSE: begin
                    if (w_last) begin
                        r_state <= S_CMD_HOLD;
                        r_cnt   <= '0;
                        r_we_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CMD_HOLD: begin
                    r_flash_data_oe <= 1'b0;
                    r_cnt           <= '0;
                    if (NO_WORDS) begin
                        r_state <= S_DONE;
                        r_ce_n  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RD_LO;
                        r_oe_n  <= 1'b0;
                    end
                end
                S_RD_LO: begin
                    if (w_last) begin
                        r_ram_wdata[15:0] <= flash_data_i;
                        r_flash_addr      <= r_flash_addr + 22'd1;
                        r_cnt             <= '0;
                        r_state           <= S_RD_HI;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RD_HI: begin
                    if (w_last) begin
                        r_ram_wdata[31:16] <= flash_data_i;
                        r_ce_n             <= 1'b1;
                        r_oe_n             <= 1'b1;
                        r_ram_we           <= 1'b1;
                        r_ram_addr         <= w_ram_addr_k;
                        r_cnt              <= '0;
                        r_state            <= S_RAM_WR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RAM_WR: begin
                    if (ram_ack) begin
                        r_ram_we <= 1'b0;
                        if (r_k == K_LAST) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_k          <= r_k + 1'b1;
                            r_flash_addr <= r_flash_addr + 22'd1;
                            r_ce_n       <= 1'b0;
                            r_oe_n       <= 1'b0;
                            r_state      <= S_RD_LO;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign flash_addr    = r_flash_addr;
    assign flash_data_o  = r_flash_data_o;
    assign flash_data_oe = r_flash_data_oe;
    assign flash_ce_n    = r_ce_n;
    assign flash_oe_n    = r_oe_n;
    assign flash_we_n    = r_we_n;
    assign ram_addr      = r_ram_addr;
    assign ram_wdata     = r_ram_wdata;
    assign ram_we        = r_ram_we;

endmodule

// File: tb/tb_flash_boot_loader.sv
// Scoreboard bench: three loaders with different geometries share one
// flash/RAM behavioural model; expected RAM writes are queued per copy.
module tb_flash_boot_loader;

    typedef struct {
        int          d;
        logic [31:0] a;
        logic [31:0] w;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        st    [3];
    logic        bsy   [3];
    logic        dn    [3];
    logic [21:0] faddr [3];
    logic [15:0] fdo   [3];
    logic [15:0] fdi   [3];
    logic        fdoe  [3];
    logic        fce   [3];
    logic        foe   [3];
    logic        fwe   [3];
    logic [31:0] raddr [3];
    logic [31:0] rwd   [3];
    logic        rwe   [3];
    logic        ack   [3];

    logic        rmode [3];
    logic        pwe   [3];
    int          wlen  [3];
    int          wcnt  [3];
    int          tgt   [3];
    int          acc   [3];
    int          dsel  [3];
    logic [31:0] cap_a [3];
    logic [31:0] cap_w [3];

    exp_t        q[$];
    int          errors;
    int          checks;
    logic        use_fixed;
    logic [31:0] seed;

    flash_boot_loader #(.WORD_COUNT(2), .FLASH_BASE(22'h0),
        .RAM_BASE(32'h100), .WAIT_CYCLES(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .busy(bsy[0]), .done(dn[0]),
        .flash_addr(faddr[0]), .flash_data_o(fdo[0]),
        .flash_data_oe(fdoe[0]), .flash_data_i(fdi[0]),
        .flash_ce_n(fce[0]), .flash_oe_n(foe[0]), .flash_we_n(fwe[0]),
        .ram_addr(raddr[0]), .ram_wdata(rwd[0]), .ram_we(rwe[0]),
        .ram_ack(ack[0]));

    flash_boot_loader #(.WORD_COUNT(0), .FLASH_BASE(22'h10),
        .RAM_BASE(32'h0), .WAIT_CYCLES(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .busy(bsy[1]), .done(dn[1]),
        .flash_addr(faddr[1]), .flash_data_o(fdo[1]),
        .flash_data_oe(fdoe[1]), .flash_data_i(fdi[1]),
        .flash_ce_n(fce[1]), .flash_oe_n(foe[1]), .flash_we_n(fwe[1]),
        .ram_addr(raddr[1]), .ram_wdata(rwd[1]), .ram_we(rwe[1]),
        .ram_ack(ack[1]));

    flash_boot_loader #(.WORD_COUNT(2), .FLASH_BASE(22'h3FFFFE),
        .RAM_BASE(32'hFFFF_FFFC), .WAIT_CYCLES(3)) u_dut2 (
        .clk(clk), .rst(rst), .start(st[2]), .busy(bsy[2]), .done(dn[2]),
        .flash_addr(faddr[2]), .flash_data_o(fdo[2]),
        .flash_data_oe(fdoe[2]), .flash_data_i(fdi[2]),
        .flash_ce_n(fce[2]), .flash_oe_n(foe[2]), .flash_we_n(fwe[2]),
        .ram_addr(raddr[2]), .ram_wdata(rwd[2]), .ram_we(rwe[2]),
        .ram_ack(ack[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wcyc(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic int wcount(input int d);
        return (d == 1) ? 0 : 2;
    endfunction

    function automatic logic [21:0] fbase(input int d);
        case (d)
            0:       return 22'h0;
            1:       return 22'h10;
            default: return 22'h3FFFFE;
        endcase
    endfunction

    function automatic logic [31:0] rbase(input int d);
        case (d)
            0:       return 32'h100;
            1:       return 32'h0;
            default: return 32'hFFFF_FFFC;
        endcase
    endfunction

    // Flash array contents as a pure function of the halfword address.
    function automatic logic [15:0] fval(input logic [21:0] a,
                                         input logic fx,
                                         input logic [31:0] sd);
        logic [31:0] x;
        if (fx) return 16'(({10'd0, a} + 32'd1) * 32'h1111);
        x = ({10'd0, a} * 32'h9E37_79B1) ^ sd;
        return x[31:16] ^ x[15:0];
    endfunction

    always_comb begin
        for (int d = 0; d < 3; d++) begin
            fdi[d] = (!fce[d] && !foe[d] && rmode[d]) ?
                     fval(faddr[d], use_fixed, seed) : 16'hBAD0;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input int d);
        chk($sformatf("reset outputs dut%0d", d),
            {bsy[d], dn[d], fce[d], foe[d], fwe[d], fdoe[d], fdo[d],
             faddr[d], rwe[d], raddr[d], rwd[d]},
            {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0,
             22'h0, 1'b0, 32'h0, 32'h0});
    endtask

    // Flash command decoder, bus-safety checker and RAM responder.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (!foe[d] && (fdoe[d] || !fwe[d])) begin
                errors++;
                $display("FAIL bus conflict dut%0d: oe_n=%0b doe=%0b we_n=%0b",
                         d, foe[d], fdoe[d], fwe[d]);
            end
            if (wcount(d) == 0) chk("no flash read dut1", foe[d], 1'b1);
            if (!bsy[d]) begin
                rmode[d] = 1'b0;
                acc[d]   = 0;
            end
            if (!fwe[d]) begin
                wlen[d]++;
            end else begin
                if (!pwe[d]) begin
                    chk($sformatf("we_n low cycles dut%0d", d),
                        wlen[d], wcyc(d));
                    if (!fce[d] && fdoe[d] && fdo[d] == 16'h00FF &&
                        faddr[d] == fbase(d))
                        rmode[d] = 1'b1;
                end
                wlen[d] = 0;
            end
            pwe[d] = fwe[d];
            if (rst) begin
                ack[d]  = 1'b0;
                wcnt[d] = 0;
            end else if (rwe[d]) begin
                if (wcnt[d] == 0) begin
                    cap_a[d] = raddr[d];
                    cap_w[d] = rwd[d];
                    tgt[d]   = (dsel[d] < 0) ? int'($urandom_range(0, 3))
                                             : dsel[d];
                end else begin
                    chk("ram_addr stable", raddr[d], cap_a[d]);
                    chk("ram_wdata stable", rwd[d], cap_w[d]);
                end
                if (wcnt[d] == tgt[d]) begin
                    ack[d]  = 1'b1;
                    acc[d] += tgt[d];
                    wcnt[d] = 0;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected write dut%0d: addr %0h data %0h",
                                 d, raddr[d], rwd[d]);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("write dut", d, e.d);
                        chk("write addr", raddr[d], e.a);
                        chk("write data", rwd[d], e.w);
                    end
                end else begin
                    ack[d] = 1'b0;
                    wcnt[d]++;
                end
            end else begin
                ack[d]  = 1'($urandom_range(0, 1));
                wcnt[d] = 0;
            end
        end
    end

    task automatic run_copy(input int d, input int extra_at);
        int n;
        int n_exp;
        for (int k = 0; k < wcount(d); k++) begin
            exp_t e;
            logic [21:0] fa;
            fa  = fbase(d) + 22'(2 * k);
            e.d = d;
            e.a = rbase(d) + 32'(4 * k);
            e.w = {fval(fa + 22'd1, use_fixed, seed), fval(fa, use_fixed, seed)};
            q.push_back(e);
        end
        @(negedge clk);
        st[d] = 1'b1;
        @(posedge clk);
        #1;
        st[d] = 1'b0;
        chk($sformatf("busy after start dut%0d", d), bsy[d], 1'b1);
        chk($sformatf("done cleared dut%0d", d), dn[d], 1'b0);
        n = 0;
        while (n < 3000) begin
            @(posedge clk);
            n++;
            #1;
            if (dn[d]) break;
            st[d] = (n == extra_at);
        end
        st[d] = 1'b0;
        n_exp = wcyc(d) + 2 + wcount(d) * (2 * wcyc(d) + 1) + acc[d];
        chk($sformatf("cycles to done dut%0d", d), n, n_exp);
        chk($sformatf("busy low in done dut%0d", d), bsy[d], 1'b0);
        chk($sformatf("all writes seen dut%0d", d), q.size(), 0);
        q.delete();
    endtask

    task automatic reset_mid_copy();
        @(negedge clk);
        st[0] = 1'b1;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("in RD_HI addr", faddr[0], fbase(0) + 22'd1);
        chk("in RD_HI oe_n", foe[0], 1'b0);
        #1;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) chk_reset(d);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle after reset", {bsy[0], dn[0], rwe[0]}, 3'b000);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        use_fixed = 1'b1;
        seed      = 32'h0;
        rst       = 1'b1;
        for (int d = 0; d < 3; d++) begin
            st[d]    = 1'b0;
            dsel[d]  = 0;
            rmode[d] = 1'b0;
            pwe[d]   = 1'b1;
            wlen[d]  = 0;
            wcnt[d]  = 0;
            tgt[d]   = 0;
            acc[d]   = 0;
            ack[d]   = 1'b0;
        end
        #3;
        for (int d = 0; d < 3; d++) chk_reset(d);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_copy(0, -1);
        dsel[0] = 3;
        run_copy(0, -1);
        dsel[0] = 0;
        run_copy(0, 8);
        run_copy(0, 17);
        reset_mid_copy();
        run_copy(0, -1);
        run_copy(1, -1);

        use_fixed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seed = $urandom;
            for (int d = 0; d < 3; d++) dsel[d] = -1;
            run_copy(0, -1);
            run_copy(2, -1);
            run_copy(1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flash_boot_loader.md
# flash_boot_loader

Copies a program image out of the board's 16-bit parallel NOR flash into word-addressed RAM after reset, so the MIPS32 core can boot from flash content. It drives the flash pins directly for the read side of the protocol: one read-array command, then paced halfword reads. Each 32-bit word it assembles is handed to the RAM port with a write/acknowledge handshake. It sits between the board flash pins and the CPU memory arbiter and is active only until `done`.

## Interface
- `WORD_COUNT`, 256, number of 32-bit words to copy.
- `FLASH_BASE`, 22'h0, flash halfword address of the first halfword.
- `RAM_BASE`, 32'h0, RAM byte address of the first word (word-aligned).
- `WAIT_CYCLES`, 16, clk cycles per flash access phase (≥2).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a copy when idle.
- `busy`  out  1  high from the cycle after accepted `start` until DONE.
- `done`  out  1  sticky high in DONE; cleared by next accepted `start`.
- `flash_addr`  out  22  flash halfword address.
- `flash_data_o`  out  16  data driven toward flash (command only).
- `flash_data_oe`  out  1  top level drives `flash_data` with `flash_data_o` when high, else Z.
- `flash_data_i`  in  16  flash data pins as read.
- `flash_ce_n`, `flash_oe_n`, `flash_we_n`  out  1 each  active-low flash strobes.
- `ram_addr`  out  32  RAM byte address.
- `ram_wdata`  out  32  RAM write data.
- `ram_we`  out  1  write request; held until acknowledged.
- `ram_ack`  in  1  RAM accepted the write this cycle.

## Operation
- States: IDLE, CMD_SETUP, CMD_PULSE, CMD_HOLD, RD_LO, RD_HI, RAM_WR, DONE.
- IDLE: all strobes high, `flash_data_oe`=0, `ram_we`=0. `start`=1 → CMD_SETUP, word index k←0, `done`←0.
- CMD_SETUP (1 cycle): `flash_ce_n`=0, `flash_data_oe`=1, `flash_data_o`=16'h00FF, `flash_addr`=FLASH_BASE.
- CMD_PULSE (WAIT_CYCLES cycles): same as CMD_SETUP plus `flash_we_n`=0.
- CMD_HOLD (1 cycle): `flash_we_n`=1, data still driven. Exit to RD_LO, or to DONE if WORD_COUNT=0.
- RD_LO (WAIT_CYCLES cycles): `flash_ce_n`=`flash_oe_n`=0, `flash_data_oe`=0, `flash_addr`=FLASH_BASE+2k. `flash_data_i` is captured into `ram_wdata[15:0]` on the edge that ends the phase.
- RD_HI: same, `flash_addr`=FLASH_BASE+2k+1, captured into `ram_wdata[31:16]` (little-endian).
- RAM_WR: strobes high, `ram_we`=1, `ram_addr`=RAM_BASE+4k. `ram_addr` and `ram_wdata` stay stable until `ram_ack`=1 is sampled. Then k←k+1 and the block goes to RD_LO, or to DONE if k+1=WORD_COUNT.
- DONE: `busy`=0, `done`=1. `start` restarts the full sequence, including the command.
- `start` while busy: ignored. `ram_ack` outside RAM_WR: ignored.
- Address arithmetic: flash addresses wrap modulo 2^22; RAM addresses wrap modulo 2^32. k counter is wide enough for WORD_COUNT.
- Never assert `flash_oe_n`=0 together with `flash_data_oe`=1, or with `flash_we_n`=0.

## Timing
- Reset values, applied immediately and asynchronously: state IDLE, `busy`=0, `done`=0, `flash_ce_n`=`flash_oe_n`=`flash_we_n`=1, `flash_data_oe`=0, `flash_data_o`=0, `flash_addr`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
- Reset mid-copy: the copy is abandoned; a new `start` is required.
- All outputs are registered; each phase counter restarts at 0 on phase entry.
- `start` sampled at edge T → CMD_SETUP and `busy`=1 from T+1.
- Command sequence: WAIT_CYCLES+2 cycles.
- Per word with `ram_ack` in the first RAM_WR cycle: 2·WAIT_CYCLES+1 cycles. Each cycle of `ram_ack` delay adds 1 cycle.
- Total with zero-wait ack: WAIT_CYCLES+2 + WORD_COUNT·(2·WAIT_CYCLES+1) cycles from T+1 to the first DONE cycle.

## Test plan
- WAIT_CYCLES=4, WORD_COUNT=2, FLASH_BASE=0, RAM_BASE=32'h100; flash model holds 0x1111,0x2222,0x3333,0x4444 at 0..3; `ram_ack` tied high -> command 0x00FF with `flash_we_n` low 4 cycles; writes (0x100,0x22221111), (0x104,0x44443333); `done` at cycle T+1+6+18.
- Same setup, `ram_ack` delayed 3 cycles per write -> `ram_we`, address and data stable through the delay; each word takes 3 extra cycles; data unchanged.
- Reset asserted during RD_HI of word 0 -> all outputs at reset values the same cycle, with no RAM write. A later `start` copies both words correctly.
- `start` pulsed during RD_LO -> ignored, with no restart and no change to k.
- WORD_COUNT=0 -> command issued, then DONE with no reads and no RAM writes.
- FLASH_BASE=22'h3FFFFE, WORD_COUNT=2 -> second word reads addresses 0 and 1, and the address wraps.
